// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch stage feeding the IF/ID register
// Single-outstanding imem fetch with one skid entry and redirect/stall/flush handling.
module ifu #(
  parameter logic [31:0]            RESET_PC    = 32'h0000_0000,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  output logic                   o_imem_req_valid,
  input  logic                   i_imem_req_ready,
  output logic [31:0]            o_imem_addr,
  input  logic                   i_imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  input  logic                   i_if2id_stall,
  input  logic                   i_if2id_flush,
  output logic [31:0]            o_pc_d,
  output logic [INSTR_WIDTH-1:0] o_instr_d,
  output logic                   o_instr_vld_d
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]             r_state;
  logic [31:0]            r_pc;
  logic [31:0]            r_inflight_pc;
  logic                   r_skid_vld;
  logic [31:0]            r_skid_pc;
  logic [INSTR_WIDTH-1:0] r_skid_instr;
  logic [31:0]            r_pc_d;
  logic [INSTR_WIDTH-1:0] r_instr_d;
  logic                   r_vld_d;

  logic w_req_valid;
  logic w_hs;
  logic w_deliver;

  // A full skid means decode already has a backlog, so no new fetch is started.
  assign w_req_valid = ~rst_sys & (r_state == S_REQ) & ~r_skid_vld & ~i_redirect;
  assign w_hs        = w_req_valid & i_imem_req_ready;
  assign w_deliver   = (r_state == S_WAIT) & i_imem_rsp_valid & ~i_redirect;

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_addr      = r_pc;
  assign o_pc_d           = r_pc_d;
  assign o_instr_d        = r_instr_d;
  assign o_instr_vld_d    = r_vld_d;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
      // An outstanding request whose response has not yet arrived must be swallowed later.
      if ((r_state != S_REQ) && !i_imem_rsp_valid) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_hs) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (i_imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_skid_vld   <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= NOP_INSTR;
      r_pc_d       <= '0;
      r_instr_d    <= NOP_INSTR;
      r_vld_d      <= 1'b0;
    end else begin
      if (i_if2id_flush || i_if2id_stall) begin
        if (i_if2id_flush) begin
          r_vld_d   <= 1'b0;
          r_instr_d <= NOP_INSTR;
        end
        if (w_deliver) begin
          r_skid_vld   <= 1'b1;
          r_skid_pc    <= r_inflight_pc;
          r_skid_instr <= i_imem_rsp_data;
        end
      end else if (r_skid_vld) begin
        r_pc_d     <= r_skid_pc;
        r_instr_d  <= r_skid_instr;
        r_vld_d    <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_deliver) begin
        r_pc_d    <= r_inflight_pc;
        r_instr_d <= i_imem_rsp_data;
        r_vld_d   <= 1'b1;
      end else begin
        r_vld_d   <= 1'b0;
        r_instr_d <= NOP_INSTR;
      end
      if (i_redirect) begin
        r_skid_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu
// Directed vector table, hand sequences for redirect/reset corners, then random traffic vs a model.
module tb_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_if2id_stall;
  logic        i_if2id_flush;
  logic [31:0] o_pc_d;
  logic [31:0] o_instr_d;
  logic        o_instr_vld_d;

  int total = 0;
  int bad   = 0;

  ifu dut (
    .clk_sys          (clk_sys),
    .rst_sys          (rst_sys),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .i_if2id_stall    (i_if2id_stall),
    .i_if2id_flush    (i_if2id_flush),
    .o_pc_d           (o_pc_d),
    .o_instr_d        (o_instr_d),
    .o_instr_vld_d    (o_instr_vld_d)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] d,
                       input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    @(negedge clk_sys);
    rst_sys          = 1'b0;
    i_imem_req_ready = rdy;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = d;
    i_if2id_stall    = st;
    i_if2id_flush    = fl;
    i_redirect       = rd;
    i_redirect_pc    = rpc;
    #1;
  endtask

  task automatic expect_req(input string name, input logic v, input logic [31:0] a);
    chk({name, "_req_valid"}, {31'd0, o_imem_req_valid}, {31'd0, v});
    if (v) chk({name, "_addr"}, o_imem_addr, a);
  endtask

  task automatic tick_chk(input string name, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    @(posedge clk_sys);
    #1;
    chk({name, "_vld"}, {31'd0, o_instr_vld_d}, {31'd0, v});
    chk({name, "_pc"}, o_pc_d, pc);
    chk({name, "_instr"}, o_instr_d, ins);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst_sys          = 1'b1;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_if2id_stall    = 1'b0;
    i_if2id_flush    = 1'b0;
    i_redirect       = 1'b0;
    i_redirect_pc    = '0;
    #1;
    chk("reset_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    chk("reset_req_valid2", {31'd0, o_imem_req_valid}, 32'd0);
    chk("reset_vld", {31'd0, o_instr_vld_d}, 32'd0);
    chk("reset_pc", o_pc_d, 32'd0);
    chk("reset_instr", o_instr_d, NOP);
  endtask

  // Reference model: what the fetch unit owes decode, kept as plain bookkeeping.
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_drop;
  logic [31:0] m_out_pc;
  ent_t        m_skid[$];
  ent_t        m_ifid;
  logic        m_vld;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  initial begin
    int cnt;
    logic [31:0] raddr;
    logic exp_req;
    logic hs, got, deliver;
    logic rdy, rsp, st, fl, rd;
    logic [31:0] rpc;
    ent_t e;

    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
    vecs[1] = '{1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00500093};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h00500093};
    vecs[3] = '{1'b0, 1'b1, 32'h00A00113, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00500093};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00500093};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h00A00113};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h4, NOP};
    vecs[7] = '{1'b0, 1'b1, 32'h00F00193, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h00F00193};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rdy, vecs[i].rsp, vecs[i].data, vecs[i].stall, vecs[i].flush, 1'b0, 32'h0);
      expect_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr);
      tick_chk($sformatf("vec%0d", i), vecs[i].vld, vecs[i].pc, vecs[i].instr);
    end

    // Redirect while waiting; the late response is dropped.
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rd1_a", 1, 32'hC);  tick_chk("rd1_a", 0, 32'h8, NOP);
    drive(0, 0, 0, 0, 0, 1, 32'h100);          expect_req("rd1_b", 0, 0);      tick_chk("rd1_b", 0, 32'h8, NOP);
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rd1_c", 0, 0);      tick_chk("rd1_c", 0, 32'h8, NOP);
    drive(1, 1, 32'hDEAD0001, 0, 0, 0, 0);     expect_req("rd1_d", 0, 0);      tick_chk("rd1_d", 0, 32'h8, NOP);
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rd1_e", 1, 32'h100); tick_chk("rd1_e", 0, 32'h8, NOP);
    drive(0, 1, 32'h11111111, 0, 0, 0, 0);     expect_req("rd1_f", 0, 0);      tick_chk("rd1_f", 1, 32'h100, 32'h11111111);

    // Redirect coinciding with the response.
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rd2_a", 1, 32'h104); tick_chk("rd2_a", 0, 32'h100, NOP);
    drive(1, 1, 32'hBAD00002, 0, 0, 1, 32'h200); expect_req("rd2_b", 0, 0);    tick_chk("rd2_b", 0, 32'h100, NOP);
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rd2_c", 1, 32'h200); tick_chk("rd2_c", 0, 32'h100, NOP);
    drive(0, 1, 32'h22222222, 0, 0, 0, 0);     expect_req("rd2_d", 0, 0);      tick_chk("rd2_d", 1, 32'h200, 32'h22222222);

    // Flush and stall together: flush wins.
    drive(0, 0, 0, 1, 1, 0, 0);                expect_req("fs", 1, 32'h204);   tick_chk("fs", 0, 32'h200, NOP);

    // Reset during a wait; the stale response afterwards is ignored.
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rs_a", 1, 32'h204); tick_chk("rs_a", 0, 32'h200, NOP);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    #1;
    chk("rs_b_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
    @(posedge clk_sys);
    #1;
    chk("rs_b_vld", {31'd0, o_instr_vld_d}, 32'd0);
    chk("rs_b_pc", o_pc_d, 32'd0);
    chk("rs_b_instr", o_instr_d, NOP);
    drive(0, 1, 32'hBAD00003, 0, 0, 0, 0);     expect_req("rs_c", 1, 32'h0);   tick_chk("rs_c", 0, 32'h0, NOP);
    drive(1, 0, 0, 0, 0, 0, 0);                expect_req("rs_d", 1, 32'h0);   tick_chk("rs_d", 0, 32'h0, NOP);
    drive(0, 1, 32'h33333333, 0, 0, 0, 0);     expect_req("rs_e", 0, 0);       tick_chk("rs_e", 1, 32'h0, 32'h33333333);

    // Random traffic against the model.
    do_reset();
    m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_out_pc = '0;
    m_skid.delete();
    m_ifid = '{32'h0, NOP}; m_vld = 1'b0;
    cnt = 0; raddr = '0;

    for (int c = 0; c < 600; c++) begin
      rdy = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = $urandom & 32'h0000_0FFC;
      rsp = (cnt == 1);
      drive(rdy, rsp, mem_word(raddr), st, fl, rd, rpc);

      exp_req = !m_out && (m_skid.size() == 0) && !rd;
      expect_req("rnd", exp_req, m_pc);

      hs      = exp_req && rdy;
      got     = m_out && rsp;
      deliver = got && !m_drop && !rd;
      e       = '{m_out_pc, mem_word(raddr)};

      if (fl) begin
        m_vld = 1'b0; m_ifid.instr = NOP;
        if (deliver) m_skid.push_back(e);
      end else if (st) begin
        if (deliver) m_skid.push_back(e);
      end else if (m_skid.size() != 0) begin
        m_ifid = m_skid.pop_front(); m_vld = 1'b1;
      end else if (deliver) begin
        m_ifid = e; m_vld = 1'b1;
      end else begin
        m_vld = 1'b0; m_ifid.instr = NOP;
      end

      if (got) m_out = 1'b0;
      if (rd) begin
        m_skid.delete();
        if (m_out) m_drop = 1'b1;
        m_pc = rpc;
      end else if (hs) begin
        m_out = 1'b1; m_drop = 1'b0; m_out_pc = m_pc;
        raddr = m_pc;
        m_pc = m_pc + 32'd4;
      end

      if (rsp) cnt = 0;
      if (hs) cnt = $urandom_range(1, 3);
      else if (cnt > 1) cnt--;

      tick_chk("rnd", m_vld, m_ifid.pc, m_ifid.instr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
